// File: rtl/onehot_burst_decoder.sv
// ============================================================================
// Module      : onehot_burst_decoder
// Description : Binary channel index -> one-hot select, bursting cnt+1 beats
//               on consecutive channels (wrapping modulo SZX).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module onehot_burst_decoder #(
   parameter int SZY = 3,
   parameter int SZX = 8
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           in_valid,
   output logic           in_ready,
   input  logic [SZY-1:0] idx,
   input  logic [SZY-1:0] cnt,
   output logic           out_valid,
   input  logic           out_ready,
   output logic [SZX-1:0] x,
   output logic           last,
   output logic           err
);

   if ((SZX < 1) || (SZX > (1 << SZY))) begin : g_param_check
      $error("onehot_burst_decoder: SZX must be in 1..2**SZY");
   end

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   localparam logic [SZY:0]   c_szx     = (SZY+1)'(SZX);
   localparam logic [SZY-1:0] c_top     = SZY'(SZX - 1);
   localparam logic [SZY-1:0] c_rem_one = SZY'(1);
   localparam logic [SZX-1:0] c_one     = SZX'(1);

   state_t         r_state, w_state_nxt;
   logic [SZY-1:0] r_ptr, w_ptr_nxt;
   logic [SZY-1:0] r_rem, w_rem_nxt;
   logic [SZX-1:0] r_x, w_x_nxt;
   logic           r_last, w_last_nxt;
   logic           r_err, w_err_nxt;
   logic           w_consume;
   logic           w_accept;
   logic           w_idx_ok;

   assign out_valid = (r_state == ST_RUN);
   assign x         = r_x;
   assign last      = r_last;
   assign err       = r_err;

   // A new request may be taken while the final beat of the current burst drains.
   assign w_consume = out_valid & out_ready;
   assign in_ready  = (r_state == ST_IDLE) | (w_consume & r_last);
   assign w_accept  = in_valid & in_ready;
   assign w_idx_ok  = ({1'b0, idx} < c_szx);

   always_comb begin
      w_state_nxt = r_state;
      w_ptr_nxt   = r_ptr;
      w_rem_nxt   = r_rem;
      w_x_nxt     = r_x;
      w_last_nxt  = r_last;
      w_err_nxt   = r_err;
      if (w_accept) begin
         w_state_nxt = ST_RUN;
         if (w_idx_ok) begin
            w_ptr_nxt  = idx;
            w_rem_nxt  = cnt;
            w_x_nxt    = c_one << idx;
            w_last_nxt = (cnt == '0);
            w_err_nxt  = 1'b0;
         end else begin
            // Out-of-range index: single zero beat flagged as error, cnt ignored.
            w_ptr_nxt  = '0;
            w_rem_nxt  = '0;
            w_x_nxt    = '0;
            w_last_nxt = 1'b1;
            w_err_nxt  = 1'b1;
         end
      end else if (w_consume) begin
         if (r_rem != '0) begin
            w_ptr_nxt  = (r_ptr == c_top) ? '0 : r_ptr + c_rem_one;
            w_rem_nxt  = r_rem - c_rem_one;
            w_x_nxt    = c_one << w_ptr_nxt;
            w_last_nxt = (r_rem == c_rem_one);
         end else begin
            w_state_nxt = ST_IDLE;
            w_ptr_nxt   = '0;
            w_x_nxt     = '0;
            w_last_nxt  = 1'b0;
            w_err_nxt   = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_ptr   <= '0;
         r_rem   <= '0;
         r_x     <= '0;
         r_last  <= 1'b0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_ptr   <= w_ptr_nxt;
         r_rem   <= w_rem_nxt;
         r_x     <= w_x_nxt;
         r_last  <= w_last_nxt;
         r_err   <= w_err_nxt;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_onehot_burst_decoder.sv
// ============================================================================
// Module      : tb_onehot_burst_decoder
// Description : Directed self-checking bench for onehot_burst_decoder
//               (SZX=8 and SZX=5 instances).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_onehot_burst_decoder;

   logic       clk;
   logic       rst_n;

   logic       in_valid, in_ready, out_valid, out_ready, last, err;
   logic [2:0] idx, cnt;
   logic [7:0] x;

   logic       in_valid5, in_ready5, out_valid5, out_ready5, last5, err5;
   logic [2:0] idx5, cnt5;
   logic [4:0] x5;

   int total = 0;
   int bad   = 0;

   onehot_burst_decoder #(.SZY(3), .SZX(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready), .idx(idx), .cnt(cnt),
      .out_valid(out_valid), .out_ready(out_ready), .x(x), .last(last), .err(err)
   );

   onehot_burst_decoder #(.SZY(3), .SZX(5)) u_dut5 (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid5), .in_ready(in_ready5), .idx(idx5), .cnt(cnt5),
      .out_valid(out_valid5), .out_ready(out_ready5), .x(x5), .last(last5), .err(err5)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Output invariants, checked away from the active edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (out_valid && !err) chk("inv8_onehot", 32'($onehot(x)), 32'd1);
         else                   chk("inv8_zero", 32'(x), 32'd0);
         if (err)               chk("inv8_err_last", 32'(last), 32'd1);
         if (!out_valid)        chk("inv8_idle", {30'd0, last, err}, 32'd0);
         if (out_valid5 && !err5) chk("inv5_onehot", 32'($onehot(x5)), 32'd1);
         else                     chk("inv5_zero", 32'(x5), 32'd0);
         if (!out_valid5)         chk("inv5_idle", {30'd0, last5, err5}, 32'd0);
      end
   end

   logic [7:0] wrap_x [4];
   initial begin
      wrap_x[0] = 8'h40; wrap_x[1] = 8'h80; wrap_x[2] = 8'h01; wrap_x[3] = 8'h02;
   end

   initial begin
      rst_n = 1'b0;
      in_valid = 1'b0; idx = '0; cnt = '0; out_ready = 1'b0;
      in_valid5 = 1'b0; idx5 = '0; cnt5 = '0; out_ready5 = 1'b1;
      step(); step();
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_x", 32'(x), 32'd0);
      rst_n = 1'b1;
      step();
      chk("rst_in_ready", 32'(in_ready), 32'd1);
      chk("rst_out_valid_post", 32'(out_valid), 32'd0);

      // Single beat
      idx = 3'd5; cnt = 3'd0; in_valid = 1'b1; out_ready = 1'b1;
      step();
      in_valid = 1'b0;
      chk("single_valid", 32'(out_valid), 32'd1);
      chk("single_x", 32'(x), 32'h20);
      chk("single_last", 32'(last), 32'd1);
      chk("single_err", 32'(err), 32'd0);
      step();
      chk("single_done", 32'(out_valid), 32'd0);

      // Wrap
      idx = 3'd6; cnt = 3'd3; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      for (int i = 0; i < 4; i++) begin
         chk("wrap_x", 32'(x), 32'(wrap_x[i]));
         chk("wrap_last", 32'(last), (i == 3) ? 32'd1 : 32'd0);
         if (i < 3) chk("wrap_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      chk("wrap_done", 32'(out_valid), 32'd0);

      // Backpressure on beat 2
      idx = 3'd1; cnt = 3'd2; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("bp_beat1", 32'(x), 32'h02);
      step();
      chk("bp_beat2", 32'(x), 32'h04);
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("bp_hold_x", 32'(x), 32'h04);
         chk("bp_hold_last", 32'(last), 32'd0);
         chk("bp_hold_in_ready", 32'(in_ready), 32'd0);
         chk("bp_hold_valid", 32'(out_valid), 32'd1);
      end
      out_ready = 1'b1;
      chk("bp_release_in_ready", 32'(in_ready), 32'd0);
      step();
      chk("bp_beat3", 32'(x), 32'h08);
      chk("bp_beat3_last", 32'(last), 32'd1);
      chk("bp_beat3_in_ready", 32'(in_ready), 32'd1);
      step();
      chk("bp_done", 32'(out_valid), 32'd0);

      // Back-to-back bursts
      idx = 3'd3; cnt = 3'd1; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("b2b_x0", 32'(x), 32'h08);
      chk("b2b_last0", 32'(last), 32'd0);
      step();
      idx = 3'd0; cnt = 3'd0; in_valid = 1'b1;
      chk("b2b_x1", 32'(x), 32'h10);
      chk("b2b_last1", 32'(last), 32'd1);
      chk("b2b_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      chk("b2b_valid2", 32'(out_valid), 32'd1);
      chk("b2b_x2", 32'(x), 32'h01);
      chk("b2b_last2", 32'(last), 32'd1);
      step();
      chk("b2b_done", 32'(out_valid), 32'd0);

      // Reset mid-burst after beat 2
      idx = 3'd2; cnt = 3'd5; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("mrst_beat1", 32'(x), 32'h04);
      step();
      chk("mrst_beat2", 32'(x), 32'h08);
      rst_n = 1'b0;
      #1;
      chk("mrst_valid", 32'(out_valid), 32'd0);
      chk("mrst_x", 32'(x), 32'd0);
      chk("mrst_last", 32'(last), 32'd0);
      step();
      rst_n = 1'b1;
      step();
      chk("mrst_in_ready", 32'(in_ready), 32'd1);
      chk("mrst_out_valid", 32'(out_valid), 32'd0);
      idx = 3'd7; cnt = 3'd0; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk("mrst_fresh_x", 32'(x), 32'h80);
      step();
      chk("mrst_fresh_done", 32'(out_valid), 32'd0);

      // SZX=5: out-of-range index and non-power-of-2 wrap
      idx5 = 3'd6; cnt5 = 3'd2; in_valid5 = 1'b1;
      step();
      in_valid5 = 1'b0;
      chk("s5_err_valid", 32'(out_valid5), 32'd1);
      chk("s5_err_x", 32'(x5), 32'd0);
      chk("s5_err_err", 32'(err5), 32'd1);
      chk("s5_err_last", 32'(last5), 32'd1);
      step();
      chk("s5_err_done", 32'(out_valid5), 32'd0);
      chk("s5_err_clear", 32'(err5), 32'd0);
      idx5 = 3'd4; cnt5 = 3'd1; in_valid5 = 1'b1;
      step();
      in_valid5 = 1'b0;
      chk("s5_wrap_x0", 32'(x5), 32'h10);
      chk("s5_wrap_last0", 32'(last5), 32'd0);
      step();
      chk("s5_wrap_x1", 32'(x5), 32'h01);
      chk("s5_wrap_last1", 32'(last5), 32'd1);
      step();
      chk("s5_wrap_done", 32'(out_valid5), 32'd0);

      step();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
